// File: rtl/lane_arbiter_if.sv
// Handshake and data bundle between requesters and the lane arbiter.
// The arbiter side uses the slave modport; the requester side uses master.
interface lane_arbiter_if #(
    parameter int N2 = 5
);
    logic [N2:0] req;
    logic [N2:0] rel;
    logic [N2:0] in1;
    logic [N2:0] in2;
    logic [N2:0] gnt;
    logic [2:0]  gnt_id;
    logic        busy;
    logic        out1;
    logic        timeout;

    modport master (
        output req, rel, in1, in2,
        input  gnt, gnt_id, busy, out1, timeout
    );

    modport slave (
        input  req, rel, in1, in2,
        output gnt, gnt_id, busy, out1, timeout
    );
endinterface

// File: rtl/lane_arbiter.sv
// Round-robin lane arbiter: grants one requester at a time, bounds each grant to HOLD
// cycles and forwards the granted lane's data bit onto the shared out1.
module lane_arbiter #(
    parameter int N1   = 4,
    parameter int N2   = N1 + 1,
    parameter int HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    lane_arbiter_if.slave bus
);
    localparam int NREQ = N2 + 1;
    localparam logic [N2:0] ONE_HOT0 = {{N2{1'b0}}, 1'b1};

    if (N1 < 0 || N2 < 1 || N2 > 7 || HOLD < 2 || HOLD > 255) begin : g_bad_param
        $error("lane_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [N2:0] gnt_q, gnt_d;
    logic [2:0]  gnt_id_q, gnt_id_d;
    logic        busy_q, busy_d;
    logic        out1_q, out1_d;
    logic        timeout_q, timeout_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [2:0]  win_id_s;
    logic [N2:0] win_oh_s;
    logic        hit_s;
    int          dist_s;
    int          best_dist_s;
    logic        lane_in1_s, lane_in2_s;
    logic        normal_end_s, hold_end_s;

    // Winner is the set request with the smallest cyclic distance from ptr.
    always_comb begin
        win_id_s    = 3'd0;
        win_oh_s    = '0;
        best_dist_s = NREQ;
        dist_s      = 0;
        hit_s       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s      = (i >= int'(ptr_q)) ? (i - int'(ptr_q)) : (i + NREQ - int'(ptr_q));
            hit_s       = bus.req[i] && (dist_s < best_dist_s);
            best_dist_s = hit_s ? dist_s : best_dist_s;
            win_id_s    = hit_s ? 3'(i) : win_id_s;
            win_oh_s    = hit_s ? (ONE_HOT0 << i) : win_oh_s;
        end
    end

    // Granted-lane view; gnt_q is one-hot so masking selects lane g directly.
    always_comb begin
        lane_in1_s   = |(bus.in1 & gnt_q);
        lane_in2_s   = |(bus.in2 & gnt_q);
        normal_end_s = (|(bus.rel & gnt_q)) || !(|(bus.req & gnt_q));
        hold_end_s   = (cnt_q == 8'(HOLD - 1));
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        out1_d    = out1_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = GRANT;
                    gnt_d    = win_oh_s;
                    gnt_id_d = win_id_s;
                    busy_d   = 1'b1;
                    cnt_d    = 8'd0;
                    ptr_d    = (win_id_s == 3'(N2)) ? 3'd0 : (win_id_s + 3'd1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                out1_d = lane_in1_s ? lane_in1_s : lane_in2_s;
                cnt_d  = cnt_q + 8'd1;
                // A normal end wins over the hold limit, so no timeout then.
                if (normal_end_s || hold_end_s) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = !normal_end_s;
                end else begin
                    state_d = GRANT;
                end
            end
            GAP: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= 3'd0;
            busy_q    <= 1'b0;
            out1_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            out1_q    <= out1_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.out1    = out1_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_lane_arbiter.sv
// Directed bench for lane_arbiter: a vector table for arbitration and data forwarding,
// plus hand-written sequences for rotation, hold timeout and asynchronous reset.
module tb_lane_arbiter;
    localparam int N2 = 5;

    typedef struct packed {
        logic [N2:0] req;
        logic [N2:0] rel;
        logic [N2:0] in1;
        logic [N2:0] in2;
        logic [N2:0] gnt;
        logic [2:0]  id;
        logic        busy;
        logic        out1;
        logic        tmo;
    } vec_t;

    localparam int NV = 21;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs [NV];

    lane_arbiter_if #(.N2(N2)) bus ();

    lane_arbiter #(.N1(4), .N2(N2), .HOLD(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N2:0] r, input logic [N2:0] l,
                         input logic [N2:0] a, input logic [N2:0] b);
        bus.req = r;
        bus.rel = l;
        bus.in1 = a;
        bus.in2 = b;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [N2:0] exp_oh;
        int          exp_id;
        n_checks = 0;
        n_errors = 0;

        //            req        rel        in1        in2        gnt        id    busy  out1  tmo
        vecs[0]  = '{6'b000100, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{6'b000100, 6'b000000, 6'b000000, 6'b000100, 6'b000100, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{6'b000100, 6'b000000, 6'b000100, 6'b000000, 6'b000100, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{6'b000100, 6'b001011, 6'b000000, 6'b000000, 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{6'b000100, 6'b000000, 6'b000000, 6'b000100, 6'b000100, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{6'b000100, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'b010000, 6'b000000, 6'b000000, 6'b000000, 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{6'b010000, 6'b000000, 6'b010000, 6'b000000, 6'b010000, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{6'b000001, 6'b000001, 6'b000000, 6'b000000, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{6'b100101, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{6'b100101, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{6'b100101, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{6'b100101, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 3'd5, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{6'b100101, 6'b100000, 6'b000000, 6'b000000, 6'b000000, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd5, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        drive(6'b0, 6'b0, 6'b0, 6'b0);
        step();
        check("reset gnt", 32'(bus.gnt), 32'd0);
        check("reset gnt_id", 32'(bus.gnt_id), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset out1", 32'(bus.out1), 32'd0);
        check("reset timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].req, vecs[i].rel, vecs[i].in1, vecs[i].in2);
            step();
            check($sformatf("vec%0d gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d gnt_id", i), 32'(bus.gnt_id), 32'(vecs[i].id));
            check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d out1", i), 32'(bus.out1), 32'(vecs[i].out1));
            check($sformatf("vec%0d timeout", i), 32'(bus.timeout), 32'(vecs[i].tmo));
        end

        // Full request load, release on the second grant cycle: rotation 0..5 then 0.
        pulse_reset();
        drive(6'b111111, 6'b0, 6'b0, 6'b0);
        for (int k = 0; k < 7; k++) begin
            exp_id = k % 6;
            exp_oh = 6'b000001 << exp_id;
            step();
            check($sformatf("rr%0d gnt", k), 32'(bus.gnt), 32'(exp_oh));
            check($sformatf("rr%0d gnt_id", k), 32'(bus.gnt_id), 32'(exp_id));
            step();
            check($sformatf("rr%0d gnt2", k), 32'(bus.gnt), 32'(exp_oh));
            bus.rel = exp_oh;
            step();
            check($sformatf("rr%0d gap gnt", k), 32'(bus.gnt), 32'd0);
            check($sformatf("rr%0d gap timeout", k), 32'(bus.timeout), 32'd0);
            bus.rel = 6'b0;
            step();
            check($sformatf("rr%0d idle gnt", k), 32'(bus.gnt), 32'd0);
        end

        // Held request without release: 8 grant cycles, then a one-cycle timeout.
        pulse_reset();
        drive(6'b001000, 6'b0, 6'b0, 6'b0);
        step();
        check("hold gnt c0", 32'(bus.gnt), 32'h08);
        for (int c = 1; c < 8; c++) begin
            step();
            check($sformatf("hold gnt c%0d", c), 32'(bus.gnt), 32'h08);
        end
        step();
        check("hold gap gnt", 32'(bus.gnt), 32'd0);
        check("hold gap busy", 32'(bus.busy), 32'd0);
        check("hold timeout pulse", 32'(bus.timeout), 32'd1);
        step();
        check("hold timeout clear", 32'(bus.timeout), 32'd0);
        check("hold idle gnt", 32'(bus.gnt), 32'd0);

        // Release coinciding with the last allowed cycle ends normally.
        step();
        check("relhold gnt c0", 32'(bus.gnt), 32'h08);
        for (int c = 1; c < 8; c++) begin
            step();
            check($sformatf("relhold gnt c%0d", c), 32'(bus.gnt), 32'h08);
        end
        bus.rel = 6'b001000;
        step();
        check("relhold gap gnt", 32'(bus.gnt), 32'd0);
        check("relhold no timeout", 32'(bus.timeout), 32'd0);
        drive(6'b0, 6'b0, 6'b0, 6'b0);
        step();
        check("relhold idle timeout", 32'(bus.timeout), 32'd0);

        // Asynchronous reset in the middle of a grant.
        pulse_reset();
        drive(6'b001010, 6'b0, 6'b000010, 6'b0);
        step();
        check("arst pre gnt", 32'(bus.gnt), 32'h02);
        step();
        check("arst pre out1", 32'(bus.out1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst gnt", 32'(bus.gnt), 32'd0);
        check("arst busy", 32'(bus.busy), 32'd0);
        check("arst out1", 32'(bus.out1), 32'd0);
        check("arst gnt_id", 32'(bus.gnt_id), 32'd0);
        check("arst timeout", 32'(bus.timeout), 32'd0);
        step();
        check("arst held gnt", 32'(bus.gnt), 32'd0);
        rst = 1'b0;
        step();
        check("arst regrant gnt", 32'(bus.gnt), 32'h02);
        check("arst regrant gnt_id", 32'(bus.gnt_id), 32'd1);
        drive(6'b0, 6'b0, 6'b0, 6'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lane_arbiter.md
LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 SHALL have parameter N1, default 4, base lane index.
REQ-002 SHALL have parameter N2, default N1 + 1, top lane index; requester count is N2+1 (6 by default), legal range 1..7.
REQ-003 SHALL have parameter HOLD, default 8, maximum grant length in cycles, legal range 2..255.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  [N2:0]  per-requester access request, level.
REQ-007 SHALL have port rel  input  [N2:0]  per-requester release strobe, one cycle.
REQ-008 SHALL have port in1  input  [N2:0]  per-requester primary data bit.
REQ-009 SHALL have port in2  input  [N2:0]  per-requester alternate data bit.
REQ-010 SHALL have port gnt  output  [N2:0]  one-hot grant, registered.
REQ-011 SHALL have port gnt_id  output  3  index of granted requester, registered.
REQ-012 SHALL have port busy  output  1  high while in GRANT.
REQ-013 SHALL have port out1  output  1  shared lane result, registered.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-016 SHALL stay in IDLE while req == 0.
REQ-017 SHALL, in IDLE with req != 0, pick the first set req bit at or above rr pointer ptr, cyclically wrapping N2 -> 0.
REQ-018 SHALL enter GRANT at the next edge, with gnt = one-hot winner, gnt_id = winner, busy = 1, cnt = 0, and ptr = winner+1 (wrapping N2 -> 0).
REQ-019 SHALL, every cycle in GRANT, register out1 = in1[g] ? in1[g] : in2[g] for granted index g; out1 SHALL hold its last value outside GRANT.
REQ-020 SHALL increment cnt by 1 each GRANT cycle; cnt width 8.
REQ-021 SHALL leave GRANT to GAP when rel[g] = 1 or req[g] = 0 (normal end, timeout stays 0).
REQ-022 SHALL leave GRANT to GAP when cnt == HOLD-1 with no normal end that cycle, and pulse timeout = 1 for exactly the GAP cycle.
REQ-023 SHALL apply normal end when normal end and cnt == HOLD-1 coincide; no timeout pulse.
REQ-024 SHALL ignore rel bits of non-granted requesters in every state.
REQ-025 SHALL drive gnt = 0 and busy = 0 in GAP (exactly one cycle), then return to IDLE; arbitration resumes from IDLE, giving two idle-grant cycles between consecutive grants.
REQ-026 SHALL not change g during GRANT regardless of other req activity.
REQ-027 SHALL bound grant length to HOLD cycles: gnt high for at most HOLD consecutive cycles.
REQ-028 SHALL guarantee fairness: a continuously requesting index is granted within N2+1 grants.

Reset
REQ-029 SHALL, on rst = 1, immediately (asynchronously) force state IDLE, gnt = 0, gnt_id = 0, busy = 0, out1 = 0, timeout = 0, ptr = 0, cnt = 0.
REQ-030 SHALL abort any active grant on mid-GRANT reset with no timeout pulse; first arbitration after release of rst starts at ptr = 0.
REQ-031 SHALL not sample req at the edge where rst deasserts if rst is still high at that edge.

Verification
REQ-032 SHALL cover: reset, req = 6'b000100 held -> gnt = 6'b000100 one edge later, gnt_id = 2, busy = 1.
REQ-033 SHALL cover: req = 6'b111111 held with rel pulsed on 2nd grant cycle each time -> grant order 0,1,2,3,4,5,0; GAP cycle between each.
REQ-034 SHALL cover: req[3] held, rel never -> gnt[3] high 8 cycles, then timeout = 1 for one cycle with gnt = 0.
REQ-035 SHALL cover: granted g with in1[g] = 0, in2[g] = 1 -> out1 = 1 next edge; in1[g] = 1, in2[g] = 0 -> out1 = 1; both 0 -> out1 = 0.
REQ-036 SHALL cover: rel[g] on the cnt == 7 cycle -> GAP with timeout = 0.
REQ-037 SHALL cover: rst pulsed asynchronously mid-GRANT -> gnt, busy, out1 = 0 before next edge; next grant picks lowest set req from index 0.
